// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// reorder_buffer : two-wide in-order retirement buffer with tag writeback
//                  and branch squash of younger entries.
// Revision       : 1.0
// ============================================================================
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            disp_valid,
    input  logic [1:0][4:0]       disp_rd,
    output logic                  disp_ready,
    output logic [1:0][TAG_W-1:0] disp_tag,
    input  logic [1:0]            wb_valid,
    input  logic [1:0][TAG_W-1:0] wb_tag,
    input  logic [1:0][31:0]      wb_data,
    input  logic                  flush_valid,
    input  logic [TAG_W-1:0]      flush_tag,
    output logic [1:0]            commit_valid,
    output logic [1:0][4:0]       commit_rd,
    output logic [1:0][31:0]      commit_data,
    output logic [TAG_W:0]        count
);

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_ISSUED = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]     r_state [DEPTH];
    logic [4:0]     r_rd    [DEPTH];
    logic [31:0]    r_data  [DEPTH];
    logic [TAG_W:0] r_head;
    logic [TAG_W:0] r_tail;

    logic [TAG_W-1:0] w_h0, w_h1, w_t0, w_t1, w_flush_off;
    logic [TAG_W:0]   w_count, w_n_commit, w_n_disp, w_flush_keep;
    logic             w_flush_ok, w_do_disp;
    logic [DEPTH-1:0] w_squash, w_wb0, w_wb1;

    always_comb begin
        w_h0    = r_head[TAG_W-1:0];
        w_h1    = w_h0 + TAG_W'(1);
        w_t0    = r_tail[TAG_W-1:0];
        w_t1    = w_t0 + TAG_W'(1);
        w_count = r_tail - r_head;

        commit_valid[0] = (r_state[w_h0] == S_DONE);
        commit_valid[1] = commit_valid[0] && (r_state[w_h1] == S_DONE);
        w_n_commit      = (TAG_W+1)'(commit_valid[0]) + (TAG_W+1)'(commit_valid[1]);
        commit_rd[0]    = commit_valid[0] ? r_rd[w_h0]   : 5'd0;
        commit_rd[1]    = commit_valid[1] ? r_rd[w_h1]   : 5'd0;
        commit_data[0]  = commit_valid[0] ? r_data[w_h0] : 32'd0;
        commit_data[1]  = commit_valid[1] ? r_data[w_h1] : 32'd0;

        // Entries retiring this cycle are not yet counted as free.
        disp_ready  = (w_count <= (TAG_W+1)'(DEPTH - 2));
        disp_tag[0] = w_t0;
        disp_tag[1] = w_t1;

        w_flush_off  = flush_tag - w_h0;
        w_flush_ok   = flush_valid && ({1'b0, w_flush_off} < w_count);
        w_flush_keep = {1'b0, w_flush_off} + (TAG_W+1)'(1);
        // Never pull the tail behind entries that retire in the same cycle.
        if (w_flush_keep < w_n_commit) begin
            w_flush_keep = w_n_commit;
        end

        w_do_disp = disp_ready && disp_valid[0] && !w_flush_ok;
        w_n_disp  = !w_do_disp    ? (TAG_W+1)'(0) :
                    disp_valid[1] ? (TAG_W+1)'(2) : (TAG_W+1)'(1);

        for (int i = 0; i < DEPTH; i++) begin
            w_squash[i] = w_flush_ok
                       && ((TAG_W'(i) - w_h0) > w_flush_off)
                       && ({1'b0, TAG_W'(i) - w_h0} < w_count);
            w_wb0[i]    = wb_valid[0] && (wb_tag[0] == TAG_W'(i))
                       && (r_state[i] == S_ISSUED) && !w_squash[i];
            w_wb1[i]    = wb_valid[1] && (wb_tag[1] == TAG_W'(i))
                       && (r_state[i] == S_ISSUED) && !w_squash[i];
        end

        count = w_count;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= S_FREE;
                r_rd[i]    <= 5'd0;
                r_data[i]  <= 32'd0;
            end
        end else begin
            r_head <= r_head + w_n_commit;
            r_tail <= w_flush_ok ? (r_head + w_flush_keep) : (r_tail + w_n_disp);
            for (int i = 0; i < DEPTH; i++) begin
                if (w_squash[i]
                    || (commit_valid[0] && (TAG_W'(i) == w_h0))
                    || (commit_valid[1] && (TAG_W'(i) == w_h1))) begin
                    r_state[i] <= S_FREE;
                end else if (w_do_disp && (TAG_W'(i) == w_t0)) begin
                    r_state[i] <= S_ISSUED;
                    r_rd[i]    <= disp_rd[0];
                end else if (w_do_disp && disp_valid[1] && (TAG_W'(i) == w_t1)) begin
                    r_state[i] <= S_ISSUED;
                    r_rd[i]    <= disp_rd[1];
                end else if (w_wb1[i]) begin
                    r_state[i] <= S_DONE;
                    r_data[i]  <= wb_data[1];
                end else if (w_wb0[i]) begin
                    r_state[i] <= S_DONE;
                    r_data[i]  <= wb_data[0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// tb_reorder_buffer : directed scenarios plus randomized traffic against a
//                     queue-based program-order model.
// Revision          : 1.0
// ============================================================================
module tb_reorder_buffer;

    localparam int DEPTH = 16;
    localparam int TAG_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [1:0]            disp_valid;
    logic [1:0][4:0]       disp_rd;
    logic                  disp_ready;
    logic [1:0][TAG_W-1:0] disp_tag;
    logic [1:0]            wb_valid;
    logic [1:0][TAG_W-1:0] wb_tag;
    logic [1:0][31:0]      wb_data;
    logic                  flush_valid;
    logic [TAG_W-1:0]      flush_tag;
    logic [1:0]            commit_valid;
    logic [1:0][4:0]       commit_rd;
    logic [1:0][31:0]      commit_data;
    logic [TAG_W:0]        count;

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_rd(disp_rd),
        .disp_ready(disp_ready), .disp_tag(disp_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_data(commit_data), .count(count)
    );

    always #5 clk = ~clk;

    // Program-order model: element 0 is the oldest in-flight instruction.
    typedef struct {
        int          tag;
        logic [4:0]  rd;
        bit          done;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   m_head;
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic int m_find(int tag);
        for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].tag == tag) return k;
        end
        return -1;
    endfunction

    function automatic bit m_cv0();
        return (mq.size() > 0) && mq[0].done;
    endfunction

    function automatic bit m_cv1();
        return m_cv0() && (mq.size() > 1) && mq[1].done;
    endfunction

    task automatic set_idle();
        disp_valid  = 2'b00;
        disp_rd     = '0;
        wb_valid    = 2'b00;
        wb_tag      = '0;
        wb_data     = '0;
        flush_valid = 1'b0;
        flush_tag   = '0;
    endtask

    // One clock edge; the model consumes the same inputs the DUT samples.
    task automatic tick();
        int   k, nc, e0, e1;
        ent_t t;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_head = 0;
        end else begin
            nc = int'(m_cv0()) + int'(m_cv1());
            k  = flush_valid ? m_find(int'(flush_tag)) : -1;
            e0 = wb_valid[0] ? m_find(int'(wb_tag[0])) : -1;
            e1 = wb_valid[1] ? m_find(int'(wb_tag[1])) : -1;
            if (e0 >= 0 && (mq[e0].done || (k >= 0 && e0 > k))) e0 = -1;
            if (e1 >= 0 && (mq[e1].done || (k >= 0 && e1 > k))) e1 = -1;
            if (e0 >= 0) begin t = mq[e0]; t.done = 1'b1; t.data = wb_data[0]; mq[e0] = t; end
            if (e1 >= 0) begin t = mq[e1]; t.done = 1'b1; t.data = wb_data[1]; mq[e1] = t; end
            if (k >= 0) begin
                while (mq.size() > k + 1 && mq.size() > nc) void'(mq.pop_back());
            end else if (mq.size() <= DEPTH - 2 && disp_valid[0]) begin
                t.tag = (m_head + mq.size()) % DEPTH; t.rd = disp_rd[0]; t.done = 1'b0; t.data = '0;
                mq.push_back(t);
                if (disp_valid[1]) begin
                    t.tag = (m_head + mq.size()) % DEPTH; t.rd = disp_rd[1];
                    mq.push_back(t);
                end
            end
            repeat (nc) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (count !== 0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (disp_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", disp_ready); else n_pass++;
        n_checks++; if (disp_tag[0] !== 0 || disp_tag[1] !== 1)
            $display("FAIL reset_disp_tag: got %0d/%0d want 0/1", disp_tag[0], disp_tag[1]); else n_pass++;
        n_checks++; if (commit_valid !== 2'b00) $display("FAIL reset_commit_valid: got %b want 00", commit_valid); else n_pass++;
        n_checks++; if (commit_rd !== '0 || commit_data !== '0)
            $display("FAIL reset_commit_payload: got rd %h data %h want 0", commit_rd, commit_data); else n_pass++;
    endtask

    task automatic test_in_order();
        do_reset();
        disp_valid = 2'b11; disp_rd[0] = 5'd3; disp_rd[1] = 5'd4;
        n_checks++; if (disp_tag[0] !== 0 || disp_tag[1] !== 1)
            $display("FAIL io_disp_tag: got %0d/%0d want 0/1", disp_tag[0], disp_tag[1]); else n_pass++;
        tick(); set_idle();
        n_checks++; if (count !== 2) $display("FAIL io_count: got %0d want 2", count); else n_pass++;
        n_checks++; if (commit_valid !== 2'b00) $display("FAIL io_idle_cv: got %b want 00", commit_valid); else n_pass++;
        wb_valid = 2'b01; wb_tag[0] = 4'd1; wb_data[0] = 32'h22;
        tick(); set_idle();
        n_checks++; if (commit_valid !== 2'b00) $display("FAIL io_wait_cv: got %b want 00", commit_valid); else n_pass++;
        tick();
        wb_valid = 2'b01; wb_tag[0] = 4'd0; wb_data[0] = 32'h11;
        tick(); set_idle();
        n_checks++; if (commit_valid !== 2'b11 || commit_rd[0] !== 5'd3 || commit_rd[1] !== 5'd4)
            $display("FAIL io_commit_rd: got cv %b rd %0d/%0d want 11 3/4", commit_valid, commit_rd[0], commit_rd[1]); else n_pass++;
        n_checks++; if (commit_data[0] !== 32'h11 || commit_data[1] !== 32'h22)
            $display("FAIL io_commit_data: got %h/%h want 11/22", commit_data[0], commit_data[1]); else n_pass++;
        tick();
        n_checks++; if (count !== 0) $display("FAIL io_drain: got %0d want 0", count); else n_pass++;
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            disp_valid = 2'b11; disp_rd[0] = 5'($urandom); disp_rd[1] = 5'($urandom);
            tick();
        end
        set_idle();
        n_checks++; if (count !== 16 || disp_ready !== 1'b0)
            $display("FAIL full_state: got count %0d ready %b want 16 0", count, disp_ready); else n_pass++;
        disp_valid = 2'b11;
        tick(); set_idle();
        n_checks++; if (count !== 16) $display("FAIL full_ignore: got %0d want 16", count); else n_pass++;
        wb_valid = 2'b11; wb_tag[0] = 4'd0; wb_tag[1] = 4'd1; wb_data[0] = 32'hA0; wb_data[1] = 32'hA1;
        tick(); set_idle();
        n_checks++; if (commit_valid !== 2'b11 || disp_ready !== 1'b0)
            $display("FAIL full_commit: got cv %b ready %b want 11 0", commit_valid, disp_ready); else n_pass++;
        tick();
        n_checks++; if (count !== 14 || disp_ready !== 1'b1 || disp_tag[0] !== 0 || disp_tag[1] !== 1)
            $display("FAIL full_reopen: got count %0d ready %b tag %0d/%0d want 14 1 0/1",
                     count, disp_ready, disp_tag[0], disp_tag[1]); else n_pass++;
        disp_valid = 2'b11;
        tick(); set_idle();
        n_checks++; if (count !== 16) $display("FAIL full_wrap_count: got %0d want 16", count); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            disp_valid = 2'b11; disp_rd[0] = 5'(2*i); disp_rd[1] = 5'(2*i+1);
            tick();
        end
        set_idle();
        wb_valid = 2'b11; wb_tag[0] = 4'd0; wb_tag[1] = 4'd1;
        tick(); set_idle();
        tick();
        n_checks++; if (count !== 6) $display("FAIL flush_setup: got %0d want 6", count); else n_pass++;
        flush_valid = 1'b1; flush_tag = 4'd4;
        wb_valid = 2'b01; wb_tag[0] = 4'd6; wb_data[0] = 32'hDEAD;
        disp_valid = 2'b11;
        tick(); set_idle();
        n_checks++; if (count !== 3 || disp_tag[0] !== 5 || disp_tag[1] !== 6)
            $display("FAIL flush_trim: got count %0d tag %0d/%0d want 3 5/6", count, disp_tag[0], disp_tag[1]); else n_pass++;
        wb_valid = 2'b11; wb_tag[0] = 4'd2; wb_tag[1] = 4'd3;
        tick(); set_idle();
        wb_valid = 2'b01; wb_tag[0] = 4'd4;
        tick(); set_idle();
        tick(); tick();
        n_checks++; if (count !== 0) $display("FAIL flush_drain: got %0d want 0", count); else n_pass++;
        flush_valid = 1'b1; flush_tag = 4'd12;
        tick(); set_idle();
        n_checks++; if (count !== 0 || disp_tag[0] !== 5)
            $display("FAIL flush_outside: got count %0d tag %0d want 0 5", count, disp_tag[0]); else n_pass++;
        disp_valid = 2'b01; disp_rd[0] = 5'd9;
        tick(); set_idle();
        wb_valid = 2'b01; wb_tag[0] = 4'd5; wb_data[0] = 32'h55;
        tick(); set_idle();
        n_checks++; if (commit_valid !== 2'b01 || commit_rd[0] !== 5'd9 || commit_data[0] !== 32'h55)
            $display("FAIL flush_squashed_wb: got cv %b rd %0d data %h want 01 9 55",
                     commit_valid, commit_rd[0], commit_data[0]); else n_pass++;
    endtask

    task automatic test_head_block();
        do_reset();
        disp_valid = 2'b11; disp_rd[0] = 5'd7; disp_rd[1] = 5'd8;
        tick(); set_idle();
        wb_valid = 2'b01; wb_tag[0] = 4'd1; wb_data[0] = 32'hB1;
        tick(); set_idle();
        n_checks++; if (commit_valid !== 2'b00) $display("FAIL hb_blocked: got %b want 00", commit_valid); else n_pass++;
        tick();
        n_checks++; if (commit_valid !== 2'b00) $display("FAIL hb_still_blocked: got %b want 00", commit_valid); else n_pass++;
        wb_valid = 2'b11; wb_tag[0] = 4'd0; wb_tag[1] = 4'd0; wb_data[0] = 32'hB0; wb_data[1] = 32'hC0;
        tick(); set_idle();
        n_checks++; if (commit_valid !== 2'b11 || commit_rd[0] !== 5'd7 || commit_rd[1] !== 5'd8)
            $display("FAIL hb_release: got cv %b rd %0d/%0d want 11 7/8", commit_valid, commit_rd[0], commit_rd[1]); else n_pass++;
        n_checks++; if (commit_data[0] !== 32'hC0 || commit_data[1] !== 32'hB1)
            $display("FAIL hb_lane1_wins: got %h/%h want c0/b1", commit_data[0], commit_data[1]); else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            disp_valid = 2'b11; disp_rd[0] = 5'(i+1); disp_rd[1] = 5'(i+11);
            tick();
        end
        set_idle();
        rst_n = 1'b0;
        wb_valid = 2'b01; wb_tag[0] = 4'd0; wb_data[0] = 32'hF0;
        tick(); set_idle();
        rst_n = 1'b1;
        n_checks++; if (count !== 0 || disp_ready !== 1'b1 || disp_tag[0] !== 0 || disp_tag[1] !== 1)
            $display("FAIL mr_state: got count %0d ready %b tag %0d/%0d want 0 1 0/1",
                     count, disp_ready, disp_tag[0], disp_tag[1]); else n_pass++;
        tick();
        n_checks++; if (commit_valid !== 2'b00 || count !== 0)
            $display("FAIL mr_no_commit: got cv %b count %0d want 00 0", commit_valid, count); else n_pass++;
    endtask

    task automatic test_random();
        bit cv0, cv1;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            cv0 = m_cv0(); cv1 = m_cv1();
            n_checks++; if (count !== (TAG_W+1)'(mq.size()))
                $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, mq.size()); else n_pass++;
            n_checks++; if (disp_ready !== (mq.size() <= DEPTH - 2))
                $display("FAIL rnd_ready c%0d: got %b want %b", c, disp_ready, mq.size() <= DEPTH - 2); else n_pass++;
            n_checks++; if (int'(disp_tag[0]) != (m_head + mq.size()) % DEPTH
                            || int'(disp_tag[1]) != (m_head + mq.size() + 1) % DEPTH)
                $display("FAIL rnd_disp_tag c%0d: got %0d/%0d want %0d", c, disp_tag[0], disp_tag[1],
                         (m_head + mq.size()) % DEPTH); else n_pass++;
            n_checks++; if (commit_valid !== {cv1, cv0})
                $display("FAIL rnd_cv c%0d: got %b want %b%b", c, commit_valid, cv1, cv0); else n_pass++;
            if (cv0) begin
                n_checks++; if (commit_rd[0] !== mq[0].rd || commit_data[0] !== mq[0].data)
                    $display("FAIL rnd_c0 c%0d: got %0d/%h want %0d/%h", c, commit_rd[0], commit_data[0],
                             mq[0].rd, mq[0].data); else n_pass++;
            end
            if (cv1) begin
                n_checks++; if (commit_rd[1] !== mq[1].rd || commit_data[1] !== mq[1].data)
                    $display("FAIL rnd_c1 c%0d: got %0d/%h want %0d/%h", c, commit_rd[1], commit_data[1],
                             mq[1].rd, mq[1].data); else n_pass++;
            end
            disp_valid = 2'($urandom_range(0, 3));
            disp_rd[0] = 5'($urandom); disp_rd[1] = 5'($urandom);
            for (int l = 0; l < 2; l++) begin
                wb_valid[l] = ($urandom_range(0, 2) != 0);
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    wb_tag[l] = TAG_W'(mq[$urandom_range(0, mq.size() - 1)].tag);
                else
                    wb_tag[l] = TAG_W'($urandom_range(0, DEPTH - 1));
                wb_data[l] = $urandom;
            end
            flush_valid = ($urandom_range(0, 11) == 0);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                flush_tag = TAG_W'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                flush_tag = TAG_W'($urandom_range(0, DEPTH - 1));
            if (flush_valid && m_find(int'(flush_tag)) == 0 && cv1) flush_valid = 1'b0;
            tick();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst_n  = 1'b0;
        m_head = 0;
        #1;
        test_reset();
        test_in_order();
        test_full_wrap();
        test_flush();
        test_head_block();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
